// File: rtl/matrix_pkg.sv
// Shared types, sizes and glyph data for the 7x5 status matrix.
package matrix_pkg;

   localparam int ROWS  = 7;
   localparam int PCOLS = 5;
   localparam int LCOLS = 3;

   typedef enum logic [1:0] {
      IMG_OFF  = 2'd0,
      IMG_DRY  = 2'd1,
      IMG_OK   = 2'd2,
      IMG_FULL = 2'd3
   } img_t;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_DRIVE = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // One-hot logical column codes as produced by the upstream selector.
   localparam logic [2:0] COL0 = 3'b100;
   localparam logic [2:0] COL1 = 3'b010;
   localparam logic [2:0] COL2 = 3'b001;

   function automatic logic is_onehot3(input logic [2:0] c);
      return (c == COL0) || (c == COL1) || (c == COL2);
   endfunction

   // Logical column index 0..2; non-one-hot codes map to 0 (never lit anyway).
   function automatic logic [1:0] lcol_index(input logic [2:0] c);
      case (c)
         COL1:    return 2'd1;
         COL2:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Mirror expansion: logical 0 -> physical {0,4}, 1 -> {1,3}, 2 -> {2}.
   function automatic logic [PCOLS-1:0] expand_cols(input logic [2:0] c);
      case (c)
         COL0:    return 5'b10001;
         COL1:    return 5'b01010;
         COL2:    return 5'b00100;
         default: return 5'b00000;
      endcase
   endfunction

   // Glyph columns, bit0 = top row. Images are left/right symmetric so one
   // logical column describes both of its mirrored physical columns.
   function automatic logic [ROWS-1:0] glyph_bits(input img_t img, input logic [1:0] lcol);
      logic [ROWS-1:0] g;
      g = '0;
      case (img)
         IMG_DRY: begin
            // droplet outline
            case (lcol)
               2'd0:    g = 7'h38;
               2'd1:    g = 7'h46;
               2'd2:    g = 7'h41;
               default: g = 7'h00;
            endcase
         end
         IMG_OK: begin
            // check mark (symmetric V)
            case (lcol)
               2'd0:    g = 7'h0C;
               2'd1:    g = 7'h30;
               2'd2:    g = 7'h40;
               default: g = 7'h00;
            endcase
         end
         IMG_FULL: g = 7'h7F;
         default:  g = 7'h00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/matrix_row_driver_if.sv
// Bus between the column selector / image controller and the row driver.
interface matrix_row_driver_if;
   import matrix_pkg::*;

   // Handshake: col is level-sampled every cycle (no valid/ready; every cycle
   // carries a column). img_load is a single-cycle strobe qualifying img_sel;
   // the driver always accepts it (implicit ready=1), later strobes overwrite
   // earlier ones until the next frame start consumes the pending value.
   logic [2:0]       col;
   logic [1:0]       img_sel;
   logic             img_load;
   logic [ROWS-1:0]  rows;
   logic [PCOLS-1:0] cols_out;
   logic             frame_done;
   logic             fault;
   state_t           state_dbg;

   modport master (
      output col, img_sel, img_load,
      input  rows, cols_out, frame_done, fault, state_dbg
   );

   modport slave (
      input  col, img_sel, img_load,
      output rows, cols_out, frame_done, fault, state_dbg
   );

endinterface

// File: rtl/matrix_row_driver_glyph_rom.sv
// Combinational glyph lookup: image x logical column -> 7 row bits.
module glyph_rom
   import matrix_pkg::*;
(
   input  img_t            img,
   input  logic [1:0]      lcol,
   output logic [ROWS-1:0] row_bits
);

   // Pure table lookup.
   always_comb begin
      row_bits = glyph_bits(img, lcol);
   end

endmodule

// File: rtl/matrix_row_driver.sv
// Row/column driver for the 7x5 status matrix: blanks on every column change,
// swaps images only at frame start, and parks outputs off while col is invalid.
module matrix_row_driver
   import matrix_pkg::*;
#(
   parameter int BLANK_CYCLES   = 2,
   parameter bit ROW_ACTIVE_LOW = 1'b1,
   parameter bit COL_ACTIVE_LOW = 1'b0
) (
   input logic                clock,
   input logic                reset,
   matrix_row_driver_if.slave bus
);

   localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(BLANK_CYCLES - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      col_held_q, col_held_d;
   img_t            active_img_q, active_img_d;
   img_t            pending_img_q, pending_img_d;
   logic            frame_done_q, frame_done_d;

   logic            col_ok;
   logic            change;
   logic            frame_start;
   logic            lit;
   img_t            load_img;
   logic [ROWS-1:0] glyph;
   logic [ROWS-1:0] rows_on;
   logic [PCOLS-1:0] cols_on;

   // Register update with synchronous reset to the all-off blank state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_BLANK;
         cnt_q         <= CNT_RELOAD;
         col_held_q    <= 3'b000;
         active_img_q  <= IMG_OFF;
         pending_img_q <= IMG_OFF;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         col_held_q    <= col_held_d;
         active_img_q  <= active_img_d;
         pending_img_q <= pending_img_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // Next state: invalid col wins from any state; a change restarts the blank.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_held_d = col_held_q;
      col_ok     = is_onehot3(bus.col);
      change     = (bus.col != col_held_q);
      if (!col_ok) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_FAULT: begin
               state_d    = ST_BLANK;
               col_held_d = bus.col;
               cnt_d      = CNT_RELOAD;
            end
            ST_DRIVE: begin
               if (change) begin
                  state_d    = ST_BLANK;
                  col_held_d = bus.col;
                  cnt_d      = CNT_RELOAD;
               end
            end
            ST_BLANK: begin
               if (change) begin
                  col_held_d = bus.col;
                  cnt_d      = CNT_RELOAD;
               end else if (cnt_q == '0) begin
                  state_d = ST_DRIVE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = CNT_RELOAD;
            end
         endcase
      end
   end

   // Image registers: pending takes every strobe; active swaps only when the
   // held column becomes col0, using a same-edge strobe directly if present.
   always_comb begin
      load_img      = img_t'(bus.img_sel);
      frame_start   = (col_held_d == COL0) && (col_held_q != COL0);
      pending_img_d = bus.img_load ? load_img : pending_img_q;
      active_img_d  = active_img_q;
      if (frame_start) begin
         active_img_d = bus.img_load ? load_img : pending_img_q;
      end
      frame_done_d  = frame_start;
   end

   glyph_rom u_glyph_rom (
      .img      (active_img_q),
      .lcol     (lcol_index(col_held_q)),
      .row_bits (glyph)
   );

   // Output drive: lit only in DRIVE, then polarity applied per pin group.
   always_comb begin
      lit            = (state_q == ST_DRIVE);
      rows_on        = lit ? glyph : '0;
      cols_on        = lit ? expand_cols(col_held_q) : '0;
      bus.rows       = ROW_ACTIVE_LOW ? ~rows_on : rows_on;
      bus.cols_out   = COL_ACTIVE_LOW ? ~cols_on : cols_on;
      bus.frame_done = frame_done_q;
      bus.fault      = (state_q == ST_FAULT);
      bus.state_dbg  = state_q;
   end

endmodule
